// File: rtl/soc_nios2_master_cpu_debug_mon_seq_if.sv
// Debug RAM access port between the debug monitor sequencer and the RAM arbiter.
interface soc_nios2_master_cpu_debug_mon_seq_if #(
    parameter int AW = 8
);
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_req;
    logic          ram_we;
    logic          ram_gnt;
    logic [31:0]   ram_rdata;

    modport master (
        output ram_addr,
        output ram_wdata,
        output ram_req,
        output ram_we,
        input  ram_gnt,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_wdata,
        input  ram_req,
        input  ram_we,
        output ram_gnt,
        output ram_rdata
    );
endinterface

// File: rtl/soc_nios2_master_cpu_debug_mon_seq.sv
// Debug monitor sequencer: turns OCI memory commands from the debug stage into
// single-word debug RAM accesses, with grant timeout and busy-drop detection.
//
// state     | meaning
// ST_IDLE   | ready for a command; no RAM traffic
// ST_REQ    | ram_req held with stable addr/we/wdata until grant or timeout
// ST_RDWAIT | read granted; ram_rdata captured into MonDReg on the next edge
module soc_nios2_master_cpu_debug_mon_seq #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [37:0]                          jdo,
    input  logic                                 take_action_ocimem_a,
    input  logic                                 take_action_ocimem_b,
    input  logic                                 take_no_action_ocimem_a,
    soc_nios2_master_cpu_debug_mon_seq_if.master ram,
    output logic [31:0]                          MonDReg,
    output logic                                 monitor_ready,
    output logic                                 monitor_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDWAIT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [31:0]   wdata, wdata_nxt;
    logic [31:0]   mon_d, mon_d_nxt;
    logic [7:0]    wait_cnt, wait_cnt_nxt;
    logic          is_write, is_write_nxt;
    logic          err, err_nxt;
    logic          any_take;

    // jdo carries fields for other debug commands that this block never uses
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

    assign any_take = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            wdata    <= '0;
            mon_d    <= '0;
            wait_cnt <= '0;
            is_write <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            wdata    <= wdata_nxt;
            mon_d    <= mon_d_nxt;
            wait_cnt <= wait_cnt_nxt;
            is_write <= is_write_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        mon_d_nxt    = mon_d;
        wait_cnt_nxt = wait_cnt;
        is_write_nxt = is_write;
        err_nxt      = err;

        unique case (state)
            ST_IDLE: begin
                // strobes are priority-ordered; losers are silently ignored
                if (take_action_ocimem_a) begin
                    addr_nxt = jdo[AW+25:26];
                    err_nxt  = 1'b0;
                    if (jdo[35]) begin
                        state_nxt    = ST_REQ;
                        is_write_nxt = 1'b0;
                        wait_cnt_nxt = '0;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_nxt    = jdo[34:3];
                    err_nxt      = 1'b0;
                    state_nxt    = ST_REQ;
                    is_write_nxt = 1'b1;
                    wait_cnt_nxt = '0;
                end else if (take_no_action_ocimem_a) begin
                    err_nxt      = 1'b0;
                    state_nxt    = ST_REQ;
                    is_write_nxt = 1'b0;
                    wait_cnt_nxt = '0;
                end
            end

            ST_REQ: begin
                if (ram.ram_gnt) begin
                    if (is_write) begin
                        addr_nxt  = addr + AW'(1);
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RDWAIT;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
                if (any_take) begin
                    err_nxt = 1'b1;
                end
            end

            ST_RDWAIT: begin
                mon_d_nxt = ram.ram_rdata;
                addr_nxt  = addr + AW'(1);
                state_nxt = ST_IDLE;
                if (any_take) begin
                    err_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ram.ram_addr  = addr;
    assign ram.ram_wdata = wdata;
    assign ram.ram_req   = (state == ST_REQ);
    assign ram.ram_we    = (state == ST_REQ) && is_write;
    assign MonDReg       = mon_d;
    assign monitor_ready = (state == ST_IDLE);
    assign monitor_error = err;

endmodule

// File: tb/tb_soc_nios2_master_cpu_debug_mon_seq.sv
// Bench for the debug monitor sequencer: directed scenarios plus randomized
// commands checked against a command-level reference model.
module tb_soc_nios2_master_cpu_debug_mon_seq;
    localparam int TIMEOUT = 16;
    localparam int AW      = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0;
    logic        take_b = 1'b0;
    logic        take_n = 1'b0;
    logic [31:0] mon_d_reg;
    logic        monitor_ready;
    logic        monitor_error;

    int total = 0;
    int bad   = 0;

    // reference model: architectural state as seen from the debug host
    logic [AW-1:0] m_addr;
    logic [31:0]   m_mon;
    logic [31:0]   m_wdata;
    logic          m_err;

    soc_nios2_master_cpu_debug_mon_seq_if #(.AW(AW)) ram_if ();

    soc_nios2_master_cpu_debug_mon_seq #(
        .TIMEOUT(TIMEOUT),
        .AW     (AW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_a),
        .take_action_ocimem_b   (take_b),
        .take_no_action_ocimem_a(take_n),
        .ram                    (ram_if),
        .MonDReg                (mon_d_reg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ram_if.ram_gnt   = 1'b0;
        ram_if.ram_rdata = '0;
        reset = 1'b1;
        step();
        step();
        total++;
        if (ram_if.ram_req !== 1'b0 || ram_if.ram_we !== 1'b0 || ram_if.ram_addr !== '0 || ram_if.ram_wdata !== '0) begin
            bad++;
            $display("FAIL reset_bus: req=%b we=%b addr=%h wdata=%h, expected 0 0 00 00000000",
                     ram_if.ram_req, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wdata);
        end
        total++;
        if (mon_d_reg !== '0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_mon: mon=%h ready=%b err=%b, expected 00000000 1 0",
                     mon_d_reg, monitor_ready, monitor_error);
        end
        reset = 1'b0;
        m_addr = '0; m_mon = '0; m_wdata = '0; m_err = 1'b0;
    endtask

    task automatic test_read();
        jdo = '0; jdo[AW+25:26] = 8'h10; jdo[35] = 1'b1;
        take_a = 1'b1; step(); take_a = 1'b0; jdo = '0;
        total++;
        if (ram_if.ram_req !== 1'b1 || ram_if.ram_we !== 1'b0 || ram_if.ram_addr !== 8'h10 || monitor_ready !== 1'b0) begin
            bad++;
            $display("FAIL read_req: req=%b we=%b addr=%h ready=%b, expected 1 0 10 0",
                     ram_if.ram_req, ram_if.ram_we, ram_if.ram_addr, monitor_ready);
        end
        repeat (2) begin
            step();
            total++;
            if (ram_if.ram_req !== 1'b1 || ram_if.ram_addr !== 8'h10) begin
                bad++;
                $display("FAIL read_hold: req=%b addr=%h, expected 1 10", ram_if.ram_req, ram_if.ram_addr);
            end
        end
        ram_if.ram_gnt = 1'b1; step(); ram_if.ram_gnt = 1'b0;
        ram_if.ram_rdata = 32'hDEADBEEF;
        total++;
        if (monitor_ready !== 1'b0 || ram_if.ram_req !== 1'b0 || mon_d_reg !== 32'h0) begin
            bad++;
            $display("FAIL read_gnt1: ready=%b req=%b mon=%h, expected 0 0 00000000",
                     monitor_ready, ram_if.ram_req, mon_d_reg);
        end
        step();
        ram_if.ram_rdata = $urandom;
        total++;
        if (mon_d_reg !== 32'hDEADBEEF || ram_if.ram_addr !== 8'h11 || monitor_ready !== 1'b1) begin
            bad++;
            $display("FAIL read_done: mon=%h addr=%h ready=%b, expected deadbeef 11 1",
                     mon_d_reg, ram_if.ram_addr, monitor_ready);
        end
        m_addr = 8'h11; m_mon = 32'hDEADBEEF;
    endtask

    task automatic test_write_wrap();
        jdo = '0; jdo[AW+25:26] = 8'hFF;
        take_a = 1'b1; step(); take_a = 1'b0;
        total++;
        if (monitor_ready !== 1'b1 || ram_if.ram_req !== 1'b0 || ram_if.ram_addr !== 8'hFF) begin
            bad++;
            $display("FAIL wr_setaddr: ready=%b req=%b addr=%h, expected 1 0 ff",
                     monitor_ready, ram_if.ram_req, ram_if.ram_addr);
        end
        jdo = '0; jdo[34:3] = 32'h12345678;
        take_b = 1'b1; step(); take_b = 1'b0; jdo = '0;
        total++;
        if (ram_if.ram_req !== 1'b1 || ram_if.ram_we !== 1'b1 || ram_if.ram_addr !== 8'hFF || ram_if.ram_wdata !== 32'h12345678) begin
            bad++;
            $display("FAIL wr_req: req=%b we=%b addr=%h wdata=%h, expected 1 1 ff 12345678",
                     ram_if.ram_req, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wdata);
        end
        ram_if.ram_gnt = 1'b1; step(); ram_if.ram_gnt = 1'b0;
        total++;
        if (ram_if.ram_req !== 1'b0 || ram_if.ram_we !== 1'b0 || ram_if.ram_addr !== 8'h00 || monitor_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_wrap: req=%b we=%b addr=%h ready=%b, expected 0 0 00 1",
                     ram_if.ram_req, ram_if.ram_we, ram_if.ram_addr, monitor_ready);
        end
        m_addr = 8'h00; m_wdata = 32'h12345678;
    endtask

    task automatic test_timeout();
        int cnt;
        cnt = 0;
        take_n = 1'b1; step(); take_n = 1'b0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            if (ram_if.ram_req !== 1'b1) break;
            cnt++;
            step();
        end
        total++;
        if (cnt != TIMEOUT) begin
            bad++;
            $display("FAIL to_cycles: req high %0d cycles, expected %0d", cnt, TIMEOUT);
        end
        total++;
        if (monitor_error !== 1'b1 || monitor_ready !== 1'b1 || mon_d_reg !== m_mon || ram_if.ram_addr !== m_addr) begin
            bad++;
            $display("FAIL to_state: err=%b ready=%b mon=%h addr=%h, expected 1 1 %h %h",
                     monitor_error, monitor_ready, mon_d_reg, ram_if.ram_addr, m_mon, m_addr);
        end
        m_err = 1'b1;
    endtask

    task automatic test_busy_drop();
        logic [AW-1:0] start;
        logic [31:0]   rd;
        start = m_addr;
        rd = $urandom;
        take_n = 1'b1; step(); take_n = 1'b0;
        total++;
        if (monitor_error !== 1'b0 || ram_if.ram_req !== 1'b1) begin
            bad++;
            $display("FAIL busy_accept: err=%b req=%b, expected 0 1", monitor_error, ram_if.ram_req);
        end
        take_n = 1'b1; step(); take_n = 1'b0;
        total++;
        if (monitor_error !== 1'b1 || ram_if.ram_req !== 1'b1 || ram_if.ram_addr !== start) begin
            bad++;
            $display("FAIL busy_poke: err=%b req=%b addr=%h, expected 1 1 %h",
                     monitor_error, ram_if.ram_req, ram_if.ram_addr, start);
        end
        ram_if.ram_gnt = 1'b1; step(); ram_if.ram_gnt = 1'b0;
        ram_if.ram_rdata = rd; step(); ram_if.ram_rdata = $urandom;
        m_addr = start + 1'b1; m_mon = rd; m_err = 1'b1;
        total++;
        if (mon_d_reg !== m_mon || ram_if.ram_addr !== m_addr || monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin
            bad++;
            $display("FAIL busy_done: mon=%h addr=%h err=%b ready=%b, expected %h %h 1 1",
                     mon_d_reg, ram_if.ram_addr, monitor_error, monitor_ready, m_mon, m_addr);
        end
    endtask

    task automatic test_priority();
        logic [AW-1:0] na;
        int            seen_req;
        na = AW'($urandom);
        jdo = {6'($urandom), $urandom};
        jdo[AW+25:26] = na; jdo[35] = 1'b0;
        take_a = 1'b1; take_b = 1'b1; step(); take_a = 1'b0; take_b = 1'b0;
        m_addr = na; m_err = 1'b0;
        total++;
        if (monitor_ready !== 1'b1 || ram_if.ram_addr !== na || monitor_error !== 1'b0) begin
            bad++;
            $display("FAIL prio_load: ready=%b addr=%h err=%b, expected 1 %h 0",
                     monitor_ready, ram_if.ram_addr, monitor_error, na);
        end
        seen_req = 0;
        for (int i = 0; i < 4; i++) begin
            if (ram_if.ram_req !== 1'b0) seen_req++;
            step();
        end
        total++;
        if (seen_req != 0) begin
            bad++;
            $display("FAIL prio_noreq: req seen in %0d cycles, expected 0", seen_req);
        end
    endtask

    task automatic test_reset_rdwait();
        logic [31:0] rd;
        take_n = 1'b1; step(); take_n = 1'b0;
        ram_if.ram_gnt = 1'b1; step(); ram_if.ram_gnt = 1'b0;
        ram_if.ram_rdata = 32'hA5A55A5A;
        #2 reset = 1'b1;
        #1;
        total++;
        if (monitor_ready !== 1'b1 || ram_if.ram_req !== 1'b0 || ram_if.ram_we !== 1'b0 || ram_if.ram_addr !== '0 ||
            ram_if.ram_wdata !== '0 || mon_d_reg !== '0 || monitor_error !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: ready=%b req=%b we=%b addr=%h wdata=%h mon=%h err=%b, expected 1 0 0 00 00000000 00000000 0",
                     monitor_ready, ram_if.ram_req, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wdata, mon_d_reg, monitor_error);
        end
        take_n = 1'b1; step(); take_n = 1'b0;
        step();
        reset = 1'b0;
        total++;
        if (mon_d_reg !== '0 || ram_if.ram_req !== 1'b0 || monitor_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_hold: mon=%h req=%b ready=%b, expected 00000000 0 1",
                     mon_d_reg, ram_if.ram_req, monitor_ready);
        end
        step();
        rd = $urandom;
        take_n = 1'b1; step(); take_n = 1'b0;
        total++;
        if (ram_if.ram_req !== 1'b1 || ram_if.ram_addr !== '0) begin
            bad++;
            $display("FAIL rst_first: req=%b addr=%h, expected 1 00", ram_if.ram_req, ram_if.ram_addr);
        end
        ram_if.ram_gnt = 1'b1; step(); ram_if.ram_gnt = 1'b0;
        ram_if.ram_rdata = rd; step(); ram_if.ram_rdata = $urandom;
        m_addr = 8'h01; m_mon = rd; m_err = 1'b0; m_wdata = '0;
        total++;
        if (mon_d_reg !== m_mon || ram_if.ram_addr !== m_addr || monitor_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_after: mon=%h addr=%h ready=%b, expected %h %h 1",
                     mon_d_reg, ram_if.ram_addr, monitor_ready, m_mon, m_addr);
        end
    endtask

    task automatic test_random();
        logic [2:0]    s;
        logic          do_acc, wr, poke;
        int            delay;
        logic [31:0]   rd;
        for (int it = 0; it < 200; it++) begin
            s     = 3'($urandom);
            jdo   = {6'($urandom), $urandom};
            delay = $urandom_range(0, TIMEOUT + 2);
            poke  = ($urandom_range(0, 3) == 0);
            rd    = $urandom;
            do_acc = 1'b0;
            wr     = 1'b0;
            if (s[0]) begin
                m_addr = jdo[AW+25:26]; m_err = 1'b0; do_acc = jdo[35];
            end else if (s[1]) begin
                m_wdata = jdo[34:3]; m_err = 1'b0; do_acc = 1'b1; wr = 1'b1;
            end else if (s[2]) begin
                m_err = 1'b0; do_acc = 1'b1;
            end
            take_a = s[0]; take_b = s[1]; take_n = s[2];
            step();
            take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
            if (do_acc) begin
                total++;
                if (ram_if.ram_req !== 1'b1 || ram_if.ram_we !== wr || ram_if.ram_addr !== m_addr ||
                    (wr && ram_if.ram_wdata !== m_wdata)) begin
                    bad++;
                    $display("FAIL rnd_req it=%0d: req=%b we=%b addr=%h wdata=%h, expected 1 %b %h %h",
                             it, ram_if.ram_req, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wdata, wr, m_addr, m_wdata);
                end
                for (int c = 0; c < TIMEOUT; c++) begin
                    take_n = poke && (c == 0);
                    ram_if.ram_gnt = (c == delay);
                    step();
                    take_n = 1'b0;
                    ram_if.ram_gnt = 1'b0;
                    if (c == delay) break;
                end
                if (delay < TIMEOUT) begin
                    m_addr = m_addr + 1'b1;
                    if (!wr) begin
                        ram_if.ram_rdata = rd; step(); ram_if.ram_rdata = $urandom;
                        m_mon = rd;
                    end
                end else begin
                    m_err = 1'b1;
                end
                if (poke) m_err = 1'b1;
            end
            total++;
            if (monitor_ready !== 1'b1 || ram_if.ram_req !== 1'b0 || ram_if.ram_addr !== m_addr ||
                mon_d_reg !== m_mon || monitor_error !== m_err) begin
                bad++;
                $display("FAIL rnd_idle it=%0d: ready=%b req=%b addr=%h mon=%h err=%b, expected 1 0 %h %h %b",
                         it, monitor_ready, ram_if.ram_req, ram_if.ram_addr, mon_d_reg, monitor_error, m_addr, m_mon, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wrap();
        test_timeout();
        test_busy_drop();
        test_priority();
        test_reset_rdwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
